// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared multicycle RISC-V datapath (fetch/decode/execute/memory/writeback).
// Optional illegal-opcode trap state is enabled by defining ILLEGAL_OP_EN.
module multicycle_controller #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    EXECI    = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BEQ      = STATE_W'(9),
    JAL      = STATE_W'(10),
    TRAP     = STATE_W'(11)
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t      state, state_next;
  logic [1:0]  aluop;
  logic        branch;
  logic        pcupdate;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:    state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECR;
          OP_ITYPE:          state_next = EXECI;
          OP_BEQ:            state_next = BEQ;
          OP_JAL:            state_next = JAL;
`ifdef ILLEGAL_OP_EN
          default:           state_next = TRAP;
`else
          default:           state_next = FETCH;
`endif
        endcase
      end
      MEMADR:   state_next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  state_next = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_next = FETCH;
      MEMWRITE: state_next = mem_ready ? FETCH : MEMWRITE;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BEQ:      state_next = FETCH;
      JAL:      state_next = ALUWB;
`ifdef ILLEGAL_OP_EN
      TRAP:     state_next = TRAP;
`endif
      default:  state_next = FETCH;
    endcase
  end

  always_comb begin
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    aluop     = 2'b00;
    branch    = 1'b0;
    pcupdate  = 1'b0;
    illegal   = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pcupdate  = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = 2'b10;
      end
      ALUWB:    RegWrite = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
      end
`ifdef ILLEGAL_OP_EN
      TRAP:     illegal = 1'b1;
`endif
      default: ;
    endcase
    // Reset presents the FETCH datapath setup with every write strobe suppressed.
    if (reset) begin
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = 2'b10;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b10;
      RegWrite  = 1'b0;
      aluop     = 2'b00;
      branch    = 1'b0;
      pcupdate  = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign PCWrite = pcupdate | (branch & zero);

  always_comb begin
    case (op)
      OP_LOAD, OP_ITYPE: ImmSrc = 2'b00;
      OP_STORE:          ImmSrc = 2'b01;
      OP_BEQ:            ImmSrc = 2'b10;
      OP_JAL:            ImmSrc = 2'b11;
      default:           ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (aluop)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  assign state_o = state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore-style control FSM that sequences the shared multicycle RISC-V datapath: one ALU, one unified instruction/data memory port and one register file, used over several cycles per instruction. It decodes the latched instruction fields and steps the datapath through fetch, decode, execute, memory and writeback. It replaces the single-cycle control path and drives all datapath mux selects and write strobes. A memory-ready handshake stretches the memory states.

Parameters:
STATE_W, 4, width of the state register and of the state_o debug port

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
op  input  7  opcode from instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag
mem_ready  input  1  memory port has completed the current access
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction and OldPC register enable
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 data
ALUSrcB  output  2  00=rs2 data, 01=ImmExt, 10=constant 4
RegWrite  output  1  register file write enable
ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal  output  1  illegal-opcode flag (optional feature only, else tied 0)
state_o  output  STATE_W  current state, debug

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on port reset.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Reset: the first rising clk with reset=1 forces state to FETCH. Reset mid-instruction abandons that instruction.
- While reset=1: PCWrite, IRWrite, RegWrite and MemWrite are forced 0. All other outputs take their FETCH values.
- Outputs are a combinational function of state, except PCWrite and IRWrite, which are gated as described below. Any output not listed for a state is 0.
- FETCH outputs:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCUpdate are asserted only while mem_ready=1.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> FETCH
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1. Hold while mem_ready=0; go to MEMWB when mem_ready=1.
- MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 for every cycle in the state. Hold until mem_ready=1, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state ALUWB.
- PCWrite = PCUpdate | (Branch & zero).
- ImmSrc is decoded from op in every state:
  - 0000011 or 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - other op -> 00
- ALUControl is decoded from the internal ALUOp:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10, funct3 000 -> 001 if (op[5] & funct7b5), else 000.
  - ALUOp 10, funct3 010 -> 101; funct3 110 -> 011; funct3 111 -> 010; any other funct3 -> 000.
- Cycle counts with mem_ready held at 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type, I-type ALU, jal: 4 cycles
  - beq: 3 cycles
  - unknown opcode: 2 cycles
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Optional Feature:
Macro ILLEGAL_OP_EN.
- Defined:
  - An unknown op in DECODE goes to TRAP.
  - TRAP drives all strobes 0 and illegal=1.
  - TRAP is held until reset; illegal is 0 in all other states.
- Undefined:
  - TRAP is unreachable; an unknown op goes DECODE -> FETCH.
  - illegal is tied 0.

Test Plan:
- Reset held 3 cycles with mem_ready=1 -> PCWrite, IRWrite, RegWrite and MemWrite are 0 throughout; state_o=0 on release; next cycle state_o=1.
- lw (op=0000011), mem_ready=1 -> states 0,1,2,3,4,0; MemWB has RegWrite=1 and ResultSrc=01; ImmSrc=00; PCWrite=1 only in FETCH.
- sw with mem_ready low 2 cycles in MEMWRITE -> MemWrite=1 for 3 consecutive cycles, then FETCH; ImmSrc=01; RegWrite never asserted.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECR; then ALUWB with RegWrite=1. Same fields with op=0010011 -> ALUControl=000.
- beq with zero=1 -> PCWrite=1 in BEQ and ALUControl=001. With zero=0 -> PCWrite=0; both cases return to FETCH.
- op=0000000 -> with ILLEGAL_OP_EN, state_o=11 and illegal=1, held 10 cycles until reset. Without it, FETCH follows DECODE and illegal=0.
